graph_loader: RTL and testbench
===============================

GRAPH_LOADER -- requirements
Module: graph_loader

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port start  input  1  one-cycle pulse; arms a new load.
REQ-004 SHALL have port in_valid  input  1  software byte valid.
REQ-005 SHALL have port in_data  input  8  software byte.
REQ-006 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-007 SHALL have port wr_en  output  4  per-lane write enables for graph memories 0..3.
REQ-008 SHALL have port wr_addr  output  5  node address shared by all four lanes.
REQ-009 SHALL have port wr_data  output  32  lane i data in bits [8i+7:8i].
REQ-010 SHALL have port node_count  output  6  N latched from the stream.
REQ-011 SHALL have port done  output  1  load complete, level.
REQ-012 SHALL have port error  output  1  malformed stream, sticky level.

Function
REQ-013 SHALL accept a byte only on a cycle where in_valid and in_ready are both 1.
REQ-014 SHALL hold in_ready at 1 only in GET_N, GET_HDR, GET_EDGE and GET_CK, and at 0 in every other state.
REQ-015 SHALL implement the states IDLE, GET_N, GET_HDR, GET_EDGE, WRITE, GET_CK, CLEAR, DONE and ERR.
REQ-016 SHALL move to GET_N on the cycle after start=1 from any state, and SHALL clear done, error, the node counter and the edge buffer.
REQ-017 SHALL, in GET_N, latch the accepted byte as N; N outside 1..32 SHALL go to ERR, otherwise to GET_HDR.
REQ-018 SHALL, in GET_HDR, take in_data[2:0] as the edge count C for the current node; C>4 or in_data[7:3]!=0 SHALL go to ERR.
REQ-019 SHALL, in GET_HDR, go to WRITE when C=0, and to GET_EDGE otherwise.
REQ-020 SHALL, in GET_EDGE, store edge byte {idx[4:0],dist[2:0]} into lane k, where k is its arrival order 0..C-1.
REQ-021 SHALL go to ERR on any edge byte with dist=0 or idx>=N.
REQ-022 SHALL go to WRITE after the C-th edge byte is accepted.
REQ-023 SHALL, in WRITE, hold wr_en=4'b1111 for exactly one cycle with wr_addr equal to the current node index; unused lanes SHALL carry 8'h00.
REQ-024 SHALL leave WRITE for GET_HDR when more nodes remain, and otherwise for GET_CK (macro defined) or CLEAR (macro undefined).
REQ-025 SHALL, in CLEAR, write 32'h0 to addresses N..31 one per cycle with wr_en=4'b1111, then go to DONE; N=32 SHALL go straight to DONE with no clear writes.
REQ-026 SHALL hold done=1 in DONE and error=1 in ERR until reset or start.
REQ-027 SHALL keep wr_en=0 in every state other than WRITE and CLEAR.
REQ-028 SHALL count nodes 0..N-1 in ascending order with no wrap; node index 31 is the last legal index.
REQ-029 SHALL not issue any further writes after entering ERR; entries already written are left as written.

Reset
REQ-030 SHALL, on reset=1 at a clock edge, load state=IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, node_count=0, done=0, error=0 and clear the internal buffers.
REQ-031 SHALL let reset take priority over a simultaneous start, including when reset is asserted mid-load; no write SHALL occur on the reset cycle.

Configuration
REQ-032 SHALL, with GRAPH_LOADER_CKSUM_EN defined, require in GET_CK one trailing byte equal to the XOR of every previously accepted byte of the load; a match SHALL go to CLEAR and a mismatch to ERR.
REQ-033 SHALL, with GRAPH_LOADER_CKSUM_EN undefined, omit GET_CK and the XOR accumulator entirely, and a trailing byte SHALL not be consumed.

Verification
REQ-034 SHALL cover: start; stream 02,01,0C,01,04 -> addr0 lanes {0C,00,00,00}, addr1 {04,00,00,00}, then 30 clear writes (addr 2..31), then done=1.
REQ-035 SHALL cover: N=8'h00 or 8'h21 -> error=1 one cycle after acceptance, wr_en never asserted.
REQ-036 SHALL cover: header 8'h05 -> ERR; edge 8'h08 (dist=0) -> ERR; edge idx>=N -> ERR.
REQ-037 SHALL cover: in_valid toggled 50% randomly -> wr_en/wr_data sequence identical to the back-to-back run; no byte is accepted while in_ready=0.
REQ-038 SHALL cover: reset asserted in GET_EDGE -> all outputs at reset values next cycle; start during CLEAR -> GET_N next cycle with no further clear writes.
REQ-039 SHALL cover, with GRAPH_LOADER_CKSUM_EN defined: stream 01,00,01 -> done=1; stream 01,00,00 -> error=1.

Source files
------------

// File: rtl/graph_loader.sv
// Byte-stream graph loader: parses N, per-node edge headers and edge bytes into four lane memories.
// Optional trailing XOR checksum enabled by defining GRAPH_LOADER_CKSUM_EN.
module graph_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [3:0]  wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic [5:0]  node_count,
  output logic        done,
  output logic        error
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    GET_N    = 4'd1,
    GET_HDR  = 4'd2,
    GET_EDGE = 4'd3,
    WRITE    = 4'd4,
    CLEAR    = 4'd5,
    DONE     = 4'd6,
    ERR      = 4'd7
`ifdef GRAPH_LOADER_CKSUM_EN
    , GET_CK = 4'd8
`endif
  } state_t;

  state_t      state, state_nx;
  logic [5:0]  n, n_nx;
  logic [4:0]  node, node_nx;
  logic [2:0]  cnt, cnt_nx;
  logic [2:0]  k, k_nx;
  logic [31:0] ebuf, ebuf_nx;
  logic [4:0]  clr, clr_nx;
  logic        acc;
`ifdef GRAPH_LOADER_CKSUM_EN
  logic [7:0]  ck, ck_nx;
`endif

  logic        ready_nx;
  logic [3:0]  wr_en_nx;
  logic [4:0]  wr_addr_nx;
  logic [31:0] wr_data_nx;

  assign acc = in_valid & in_ready;

  // Next-state, datapath and next-output decode.
  always_comb begin
    state_nx = state;
    n_nx     = n;
    node_nx  = node;
    cnt_nx   = cnt;
    k_nx     = k;
    ebuf_nx  = ebuf;
    clr_nx   = clr;
`ifdef GRAPH_LOADER_CKSUM_EN
    ck_nx    = acc ? (ck ^ in_data) : ck;
`endif
    case (state)
      IDLE: begin
        state_nx = IDLE;
      end
      GET_N: begin
        if (acc) begin
          n_nx = in_data[5:0];
          if (in_data == 8'd0 || in_data > 8'd32) begin
            state_nx = ERR;
          end else begin
            state_nx = GET_HDR;
          end
        end else begin
          state_nx = GET_N;
        end
      end
      GET_HDR: begin
        if (acc) begin
          cnt_nx  = in_data[2:0];
          k_nx    = 3'd0;
          ebuf_nx = 32'h0;
          if (in_data[7:3] != 5'd0 || in_data[2:0] > 3'd4) begin
            state_nx = ERR;
          end else if (in_data[2:0] == 3'd0) begin
            state_nx = WRITE;
          end else begin
            state_nx = GET_EDGE;
          end
        end else begin
          state_nx = GET_HDR;
        end
      end
      GET_EDGE: begin
        if (acc) begin
          if (in_data[2:0] == 3'd0 || {1'b0, in_data[7:3]} >= n) begin
            state_nx = ERR;
          end else begin
            ebuf_nx[{k[1:0], 3'b000} +: 8] = in_data;
            k_nx = k + 3'd1;
            if (k + 3'd1 == cnt) begin
              state_nx = WRITE;
            end else begin
              state_nx = GET_EDGE;
            end
          end
        end else begin
          state_nx = GET_EDGE;
        end
      end
      WRITE: begin
        if ({1'b0, node} == n - 6'd1) begin
`ifdef GRAPH_LOADER_CKSUM_EN
          state_nx = GET_CK;
`else
          if (n == 6'd32) begin
            state_nx = DONE;
          end else begin
            state_nx = CLEAR;
            clr_nx   = n[4:0];
          end
`endif
        end else begin
          node_nx  = node + 5'd1;
          state_nx = GET_HDR;
        end
      end
`ifdef GRAPH_LOADER_CKSUM_EN
      GET_CK: begin
        if (acc) begin
          if (in_data != ck) begin
            state_nx = ERR;
          end else if (n == 6'd32) begin
            state_nx = DONE;
          end else begin
            state_nx = CLEAR;
            clr_nx   = n[4:0];
          end
        end else begin
          state_nx = GET_CK;
        end
      end
`endif
      CLEAR: begin
        if (clr == 5'd31) begin
          state_nx = DONE;
        end else begin
          clr_nx   = clr + 5'd1;
          state_nx = CLEAR;
        end
      end
      DONE: begin
        state_nx = DONE;
      end
      ERR: begin
        state_nx = ERR;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    // A new load abandons whatever was in flight, including any byte offered this cycle.
    if (start) begin
      state_nx = GET_N;
      n_nx     = 6'd0;
      node_nx  = 5'd0;
      cnt_nx   = 3'd0;
      k_nx     = 3'd0;
      ebuf_nx  = 32'h0;
      clr_nx   = 5'd0;
`ifdef GRAPH_LOADER_CKSUM_EN
      ck_nx    = 8'h00;
`endif
    end else begin
      state_nx = state_nx;
    end

    ready_nx   = 1'b0;
    wr_en_nx   = 4'h0;
    wr_addr_nx = 5'd0;
    wr_data_nx = 32'h0;
    case (state_nx)
      GET_N, GET_HDR, GET_EDGE: begin
        ready_nx = 1'b1;
      end
`ifdef GRAPH_LOADER_CKSUM_EN
      GET_CK: begin
        ready_nx = 1'b1;
      end
`endif
      WRITE: begin
        wr_en_nx   = 4'hF;
        wr_addr_nx = node_nx;
        wr_data_nx = ebuf_nx;
      end
      CLEAR: begin
        wr_en_nx   = 4'hF;
        wr_addr_nx = clr_nx;
      end
      default: begin
        ready_nx = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      n          <= 6'd0;
      node       <= 5'd0;
      cnt        <= 3'd0;
      k          <= 3'd0;
      ebuf       <= 32'h0;
      clr        <= 5'd0;
`ifdef GRAPH_LOADER_CKSUM_EN
      ck         <= 8'h00;
`endif
      in_ready   <= 1'b0;
      wr_en      <= 4'h0;
      wr_addr    <= 5'd0;
      wr_data    <= 32'h0;
      node_count <= 6'd0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_nx;
      n          <= n_nx;
      node       <= node_nx;
      cnt        <= cnt_nx;
      k          <= k_nx;
      ebuf       <= ebuf_nx;
      clr        <= clr_nx;
`ifdef GRAPH_LOADER_CKSUM_EN
      ck         <= ck_nx;
`endif
      in_ready   <= ready_nx;
      wr_en      <= wr_en_nx;
      wr_addr    <= wr_addr_nx;
      wr_data    <= wr_data_nx;
      node_count <= n_nx;
      done       <= (state_nx == DONE);
      error      <= (state_nx == ERR);
    end
  end

endmodule

// File: tb/tb_graph_loader.sv
// Scoreboard bench for graph_loader: expected writes are queued as streams are driven and
// popped by a negedge monitor whenever wr_en is active.
module tb_graph_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [3:0]  wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [5:0]  node_count;
  logic        done;
  logic        error;

  int errors = 0;
  int checks = 0;
  logic [36:0] exp_q[$];

  graph_loader dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .node_count(node_count), .done(done), .error(error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Write monitor: every active write must match the head of the expected queue.
  always @(negedge clk) begin
    logic [36:0] e;
    if (wr_en !== 4'h0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write wr_en=%h addr=%0d data=%h (no write expected)", wr_en, wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({wr_en, wr_addr, wr_data} !== {4'hF, e}) begin
          errors++;
          $display("FAIL write got en=%h addr=%0d data=%h want en=f addr=%0d data=%h",
                   wr_en, wr_addr, wr_data, e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    int n;
    if (gap && $urandom_range(0, 1) == 1) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout byte=%h in_ready=%b want 1", b, in_ready);
    end else begin
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Sends a well-formed stream, adding the trailing checksum byte when that feature is built in.
  task automatic send_stream(input logic [7:0] bytes[$], input bit gap);
    logic [7:0] x;
    x = 8'h00;
    foreach (bytes[i]) begin
      send(bytes[i], gap);
      x = x ^ bytes[i];
    end
`ifdef GRAPH_LOADER_CKSUM_EN
    send(x, gap);
`endif
  endtask

  task automatic wait_end(output bit ok);
    int n;
    n = 0;
    while (done !== 1'b1 && error !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = (done === 1'b1 || error === 1'b1);
  endtask

  task automatic push_basic_exp();
    exp_q.push_back({5'd0, 32'h0000000C});
    exp_q.push_back({5'd1, 32'h00000004});
    for (int a = 2; a < 32; a++) exp_q.push_back({a[4:0], 32'h0});
  endtask

  task automatic check_finished(input string name, input logic [5:0] n_exp);
    bit ok;
    wait_end(ok);
    checks++;
    if (!ok || done !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL %s_done done=%b error=%b want done=1 error=0", name, done, error);
    end
    checks++;
    if (node_count !== n_exp) begin
      errors++;
      $display("FAIL %s_node_count got=%0d want=%0d", name, node_count, n_exp);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_writes got=%0d pending want=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_outputs_reset(input string name);
    checks++;
    if ({in_ready, wr_en, wr_addr, wr_data, node_count, done, error} !== 50'h0) begin
      errors++;
      $display("FAIL %s rdy=%b en=%h addr=%0d data=%h n=%0d done=%b err=%b want all 0",
               name, in_ready, wr_en, wr_addr, wr_data, node_count, done, error);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_outputs_reset("reset_state");
    reset = 1'b0;
    @(negedge clk);
    check_outputs_reset("idle_after_reset");
  endtask

  task automatic test_basic();
    logic [7:0] s[$];
    push_basic_exp();
    pulse_start();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_ready_after_start got=%b want=1", in_ready);
    end
    s = '{8'h02, 8'h01, 8'h0C, 8'h01, 8'h04};
    send_stream(s, 1'b0);
    check_finished("basic", 6'd2);
    // Offer a trailing byte in DONE: it must not be taken and nothing may change.
    in_valid = 1'b1;
    in_data  = 8'hFF;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || in_ready !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold_done done=%b rdy=%b err=%b want 1,0,0", done, in_ready, error);
    end
  endtask

  task automatic test_bad_n();
    logic [7:0] v[2];
    v[0] = 8'h00;
    v[1] = 8'h21;
    for (int i = 0; i < 2; i++) begin
      pulse_start();
      send(v[i], 1'b0);
      checks++;
      if (error !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL bad_n_%h error=%b done=%b want error=1 done=0", v[i], error, done);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (error !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bad_n_sticky_%h error=%b rdy=%b want 1,0", v[i], error, in_ready);
      end
    end
    pulse_start();
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL start_clears_error got=%b want=0", error);
    end
  endtask

  task automatic test_bad_stream();
    logic [7:0] bad[3];
    bad[0] = 8'h05;
    bad[1] = 8'h08;
    bad[2] = 8'h11;
    for (int i = 0; i < 3; i++) begin
      pulse_start();
      send(8'h02, 1'b0);
      if (i > 0) send(8'h01, 1'b0);
      send(bad[i], 1'b0);
      checks++;
      if (error !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL bad_stream_%h error=%b done=%b want error=1 done=0", bad[i], error, done);
      end
    end
    // A header with nonzero upper bits is malformed even when the low count is legal.
    pulse_start();
    send(8'h02, 1'b0);
    send(8'h09, 1'b0);
    checks++;
    if (error !== 1'b1) begin
      errors++;
      $display("FAIL bad_hdr_upper error=%b want=1", error);
    end
  endtask

  task automatic test_random_valid();
    logic [7:0] s[$];
    for (int r = 0; r < 3; r++) begin
      push_basic_exp();
      pulse_start();
      s = '{8'h02, 8'h01, 8'h0C, 8'h01, 8'h04};
      send_stream(s, 1'b1);
      check_finished("random_valid", 6'd2);
    end
  endtask

  task automatic test_full();
    logic [7:0] s[$];
    for (int a = 0; a < 32; a++) exp_q.push_back({a[4:0], 32'h0});
    s.push_back(8'h20);
    for (int a = 0; a < 31; a++) s.push_back(8'h00);
    // Last node points at index 31 with distance 7: largest legal edge.
    s.push_back(8'h01);
    s.push_back(8'hFF);
    void'(exp_q.pop_back());
    exp_q.push_back({5'd31, 32'h000000FF});
    pulse_start();
    send_stream(s, 1'b0);
    check_finished("full32", 6'd32);
  endtask

  task automatic test_reset_mid();
    pulse_start();
    send(8'h02, 1'b0);
    send(8'h01, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_outputs_reset("reset_mid_edge");
    start = 1'b1;
    @(negedge clk);
    check_outputs_reset("reset_beats_start");
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_start_in_clear();
    exp_q.push_back({5'd0, 32'h0});
    for (int a = 1; a < 4; a++) exp_q.push_back({a[4:0], 32'h0});
    pulse_start();
    send(8'h01, 1'b0);
    send(8'h00, 1'b0);
`ifdef GRAPH_LOADER_CKSUM_EN
    send(8'h01, 1'b0);
    repeat (2) @(negedge clk);
`else
    repeat (3) @(negedge clk);
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || wr_en !== 4'h0 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_in_clear rdy=%b en=%h done=%b want 1,0,0", in_ready, wr_en, done);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL start_in_clear_writes pending=%0d want=0", exp_q.size());
      exp_q.delete();
    end
  endtask

`ifdef GRAPH_LOADER_CKSUM_EN
  task automatic test_cksum();
    bit ok;
    for (int a = 0; a < 32; a++) exp_q.push_back({a[4:0], 32'h0});
    pulse_start();
    send(8'h01, 1'b0);
    send(8'h00, 1'b0);
    send(8'h01, 1'b0);
    check_finished("cksum_good", 6'd1);
    exp_q.push_back({5'd0, 32'h0});
    pulse_start();
    send(8'h01, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    wait_end(ok);
    checks++;
    if (error !== 1'b1 || done !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL cksum_bad error=%b done=%b pending=%0d want 1,0,0", error, done, exp_q.size());
      exp_q.delete();
    end
  endtask
`endif

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(negedge clk);
    test_reset();
    test_basic();
    test_bad_n();
    test_bad_stream();
    test_random_valid();
    test_full();
    test_reset_mid();
    test_start_in_clear();
`ifdef GRAPH_LOADER_CKSUM_EN
    test_cksum();
`endif
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
